// File: rtl/quad_step_decoder_if.sv
// Pin/bus bundle for quad_step_decoder. QDEC_INDEX_EN adds the z_i index pin and idx_o pulse.
interface quad_step_decoder_if #(
    parameter int WIDTH = 16,
    parameter int ERR_W = 8
);
    logic             a_i;
    logic             b_i;
    logic             clr_i;
    logic             step_o;
    logic             dir_o;
    logic [WIDTH-1:0] position_o;
    logic             err_o;
    logic [ERR_W-1:0] err_cnt_o;
`ifdef QDEC_INDEX_EN
    logic             z_i;
    logic             idx_o;

    modport master (
        output a_i, b_i, clr_i, z_i,
        input  step_o, dir_o, position_o, err_o, err_cnt_o, idx_o
    );
    modport slave (
        input  a_i, b_i, clr_i, z_i,
        output step_o, dir_o, position_o, err_o, err_cnt_o, idx_o
    );
`else
    modport master (
        output a_i, b_i, clr_i,
        input  step_o, dir_o, position_o, err_o, err_cnt_o
    );
    modport slave (
        input  a_i, b_i, clr_i,
        output step_o, dir_o, position_o, err_o, err_cnt_o
    );
`endif
endinterface

// File: rtl/quad_step_decoder.sv
// Quadrature decoder: sync + glitch filter per pin, step/dir decode, wrapping position, error count.
// Optional index (z) zeroing is enabled by defining QDEC_INDEX_EN.
module quad_step_decoder #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4,
    parameter int ERR_W       = 8
) (
    input  logic                clk,
    input  logic                rst,
    quad_step_decoder_if.slave  bus
);

`ifdef QDEC_INDEX_EN
    localparam int NPIN = 3;
`else
    localparam int NPIN = 2;
`endif
    localparam int CNT_W  = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam int WARM   = SYNC_STAGES + FILT_LEN + 1;
    localparam int WARM_W = $clog2(WARM + 1);

    logic [NPIN-1:0] pin_raw;
    logic [NPIN-1:0] filt;

    assign pin_raw[0] = bus.b_i;
    assign pin_raw[1] = bus.a_i;
`ifdef QDEC_INDEX_EN
    assign pin_raw[2] = bus.z_i;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NPIN; gi++) begin : g_pin
            logic [SYNC_STAGES-1:0] sync_q, sync_d;
            logic [CNT_W-1:0]       cnt_q, cnt_d;
            logic                   filt_q, filt_d;
            logic                   synced;

            assign synced = sync_q[SYNC_STAGES-1];

            // Count consecutive samples disagreeing with the accepted value; any agreement restarts.
            always_comb begin
                sync_d = {sync_q[SYNC_STAGES-2:0], pin_raw[gi]};
                cnt_d  = cnt_q;
                filt_d = filt_q;
                if (synced == filt_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(FILT_LEN - 1)) begin
                    filt_d = synced;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync_q <= '0;
                    cnt_q  <= '0;
                    filt_q <= 1'b0;
                end else begin
                    sync_q <= sync_d;
                    cnt_q  <= cnt_d;
                    filt_q <= filt_d;
                end
            end

            assign filt[gi] = filt_q;
        end
    endgenerate

    logic [1:0]       ab_f;
    logic [1:0]       state_q, state_d;
    logic             init_q, init_d;
    logic [WARM_W-1:0] warm_q, warm_d;
    logic             step_q, step_d;
    logic             dir_q, dir_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] pos_q, pos_d;
    logic [ERR_W-1:0] errc_q, errc_d;
    logic             move_up, move_dn, illegal, idx_hit;

    assign ab_f = filt[1:0];

`ifdef QDEC_INDEX_EN
    logic zprev_q, zprev_d;
    logic idx_q, idx_d;

    assign idx_hit = !init_q && filt[2] && !zprev_q && (ab_f == 2'b00);
    assign zprev_d = filt[2];
    assign idx_d   = idx_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zprev_q <= 1'b0;
            idx_q   <= 1'b0;
        end else begin
            zprev_q <= zprev_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.idx_o = idx_q;
`else
    assign idx_hit = 1'b0;
`endif

    // Init holds off decoding until the sync/filter pipeline reflects the real pin levels.
    always_comb begin
        move_up = 1'b0;
        move_dn = 1'b0;
        if (!init_q) begin
            case ({state_q, ab_f})
                4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: move_up = 1'b1;
                4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: move_dn = 1'b1;
                default: ;
            endcase
        end
        illegal = !init_q && ((state_q ^ ab_f) == 2'b11);
    end

    always_comb begin
        state_d = ab_f;
        init_d  = init_q;
        warm_d  = warm_q;
        if (init_q) begin
            warm_d = warm_q + WARM_W'(1);
            if (warm_q == WARM_W'(WARM - 1)) init_d = 1'b0;
        end

        step_d = move_up | move_dn;
        err_d  = illegal;
        dir_d  = move_up ? 1'b1 : (move_dn ? 1'b0 : dir_q);

        pos_d = pos_q;
        if (bus.clr_i || idx_hit) pos_d = '0;
        else if (move_up)         pos_d = pos_q + WIDTH'(1);
        else if (move_dn)         pos_d = pos_q - WIDTH'(1);

        errc_d = errc_q;
        if (bus.clr_i)                      errc_d = '0;
        else if (illegal && (errc_q != '1)) errc_d = errc_q + ERR_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= 2'b00;
            init_q  <= 1'b1;
            warm_q  <= '0;
            step_q  <= 1'b0;
            dir_q   <= 1'b1;
            err_q   <= 1'b0;
            pos_q   <= '0;
            errc_q  <= '0;
        end else begin
            state_q <= state_d;
            init_q  <= init_d;
            warm_q  <= warm_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
            pos_q   <= pos_d;
            errc_q  <= errc_d;
        end
    end

    assign bus.step_o     = step_q;
    assign bus.dir_o      = dir_q;
    assign bus.err_o      = err_q;
    assign bus.position_o = pos_q;
    assign bus.err_cnt_o  = errc_q;

endmodule
